// File: rtl/pc_alu_core.sv
// pc_alu_core: program-counter register with a +4 incrementer, plus a
// combinational 32-bit integer ALU.
//
// Ports
//   clk       single clock; all state updates on the rising edge
//   rst       synchronous active-high reset; loads pc with RESET_PC
//   pc_write  PC load enable (0 = hold/stall)
//   pc_next   next PC value, chosen outside this block
//   pc        current registered PC
//   pc_plus4  pc + 4, modulo 2^PC_W
//   aluop     operation select (see alu_op_e)
//   sign      compare mode for neg: 1 = signed, 0 = unsigned
//   op1, op2  ALU operands
//   result    ALU result
//   zero      result == 0
//   neg       op1 < op2 under the sign mode, independent of aluop
module pc_alu_core #(
   parameter int              PC_W     = 12,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pc_write,
   input  logic [PC_W-1:0] pc_next,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_plus4,
   input  logic [4:0]      aluop,
   input  logic            sign,
   input  logic [31:0]     op1,
   input  logic [31:0]     op2,
   output logic [31:0]     result,
   output logic            zero,
   output logic            neg
);

   typedef enum logic [4:0] {
      OP_ADD   = 5'd0,
      OP_SUB   = 5'd1,
      OP_AND   = 5'd2,
      OP_OR    = 5'd3,
      OP_XOR   = 5'd4,
      OP_SLL   = 5'd5,
      OP_SRL   = 5'd6,
      OP_SRA   = 5'd7,
      OP_SLT   = 5'd8,
      OP_SLTU  = 5'd9,
      OP_PASSB = 5'd10
   } alu_op_e;

   // ---------------- PC ----------------
   always_ff @(posedge clk) begin
      if (rst)
         pc <= RESET_PC;
      else if (pc_write)
         pc <= pc_next;
   end

   // Wraps naturally at PC_W bits.
   assign pc_plus4 = pc + PC_W'(4);

   // ---------------- ALU ----------------
   logic [4:0] shamt;
   logic       lt_s;
   logic       lt_u;

   // Only the low five bits of op2 matter for shifts.
   assign shamt = op2[4:0];
   assign lt_s  = $signed(op1) < $signed(op2);
   assign lt_u  = op1 < op2;

   always_comb begin
      result = 32'h0;
      case (aluop)
         OP_ADD:   result = op1 + op2;
         OP_SUB:   result = op1 - op2;
         OP_AND:   result = op1 & op2;
         OP_OR:    result = op1 | op2;
         OP_XOR:   result = op1 ^ op2;
         OP_SLL:   result = op1 << shamt;
         OP_SRL:   result = op1 >> shamt;
         OP_SRA:   result = 32'($signed(op1) >>> shamt);
         OP_SLT:   result = {31'h0, lt_s};
         OP_SLTU:  result = {31'h0, lt_u};
         OP_PASSB: result = op2;
         default:  result = 32'h0;
      endcase
   end

   assign zero = (result == 32'h0);
   // Branch-compare flag: driven straight from the operands so it is valid
   // whatever aluop is selected.
   assign neg  = sign ? lt_s : lt_u;

endmodule

// File: tb/tb_pc_alu_core.sv
// Directed testbench for pc_alu_core: PC reset/load/stall/wrap and the ALU
// operations with hand-computed expected values.
module tb_pc_alu_core;

   localparam int PC_W = 12;

   logic            clk = 1'b0;
   logic            rst;
   logic            pc_write;
   logic [PC_W-1:0] pc_next;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_plus4;
   logic [4:0]      aluop;
   logic            sign;
   logic [31:0]     op1;
   logic [31:0]     op2;
   logic [31:0]     result;
   logic            zero;
   logic            neg;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pc_alu_core #(.PC_W(PC_W), .RESET_PC(12'h000)) dut (
      .clk      (clk),
      .rst      (rst),
      .pc_write (pc_write),
      .pc_next  (pc_next),
      .pc       (pc),
      .pc_plus4 (pc_plus4),
      .aluop    (aluop),
      .sign     (sign),
      .op1      (op1),
      .op2      (op2),
      .result   (result),
      .zero     (zero),
      .neg      (neg)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct packed {
      logic [4:0]  op;
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
      logic        n;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV] = '{
      '{5'd1,  1'b0, 32'h5,        32'h5,        32'h0,        1'b1, 1'b0}, // SUB 5-5
      '{5'd0,  1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0}, // ADD wrap
      '{5'd8,  1'b1, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b1}, // SLT -1<1
      '{5'd9,  1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0}, // SLTU
      '{5'd8,  1'b0, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0}, // SLT ignores sign
      '{5'd5,  1'b0, 32'h80000000, 32'h24,       32'h0,        1'b1, 1'b0}, // SLL
      '{5'd6,  1'b0, 32'h80000000, 32'h24,       32'h08000000, 1'b0, 1'b0}, // SRL
      '{5'd7,  1'b1, 32'h80000000, 32'h24,       32'hF8000000, 1'b0, 1'b1}, // SRA
      '{5'd2,  1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b1}, // AND
      '{5'd3,  1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0}, // OR
      '{5'd4,  1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b0}, // XOR
      '{5'd10, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0FF00FF0, 1'b0, 1'b0}, // PASSB
      '{5'd31, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        1'b1, 1'b0}, // unused 31
      '{5'd11, 1'b0, 32'h12345678, 32'h1,        32'h0,        1'b1, 1'b0}, // unused 11
      '{5'd0,  1'b0, 32'h7,        32'h3,        32'hA,        1'b0, 1'b0}, // ADD
      '{5'd1,  1'b0, 32'h3,        32'h7,        32'hFFFFFFFC, 1'b0, 1'b1}, // SUB neg
      '{5'd9,  1'b0, 32'h1,        32'hFFFFFFFF, 32'h1,        1'b0, 1'b1}  // SLTU 1<max
   };

   initial begin
      aluop = 5'd0; sign = 1'b0; op1 = 32'h0; op2 = 32'h0;

      // Reset overrides a pending load.
      rst = 1'b1; pc_write = 1'b1; pc_next = 12'h0A0;
      step();
      chk("rst_pc", 32'(pc), 32'h000);
      chk("rst_pc4", 32'(pc_plus4), 32'h004);

      rst = 1'b0; pc_next = 12'h010;
      step();
      chk("load_pc", 32'(pc), 32'h010);
      chk("load_pc4", 32'(pc_plus4), 32'h014);

      // Stall for three edges.
      pc_write = 1'b0; pc_next = 12'h200;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("stall_pc%0d", i), 32'(pc), 32'h010);
      end

      pc_write = 1'b1; pc_next = 12'hFFC;
      step();
      chk("wrap_pc", 32'(pc), 32'hFFC);
      chk("wrap_pc4", 32'(pc_plus4), 32'h000);

      // Mid-run reset still wins over pc_write.
      rst = 1'b1; pc_next = 12'h123;
      step();
      chk("rst2_pc", 32'(pc), 32'h000);
      rst = 1'b0; pc_write = 1'b0;

      // ALU vectors; rst toggled alongside to show it has no effect.
      for (int i = 0; i < NV; i++) begin
         rst = i[0];
         aluop = vecs[i].op; sign = vecs[i].sgn;
         op1 = vecs[i].a;    op2 = vecs[i].b;
         #1;
         chk($sformatf("res%0d", i),  result,       vecs[i].res);
         chk($sformatf("zero%0d", i), 32'(zero),    32'(vecs[i].z));
         chk($sformatf("neg%0d", i),  32'(neg),     32'(vecs[i].n));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_alu_core.md
PC_ALU_CORE -- requirements
Module: pc_alu_core

Interface
REQ-001 SHALL provide parameter PC_W, default 12, meaning program-counter width in bits.
REQ-002 SHALL provide parameter RESET_PC, default 0, meaning PC value loaded by reset.
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have pc_write  input  1  PC load enable; 0 = hold (stall).
REQ-006 SHALL have pc_next  input  PC_W  next PC value (sequential or branch target, selected externally).
REQ-007 SHALL have pc  output  PC_W  current registered PC.
REQ-008 SHALL have pc_plus4  output  PC_W  pc + 4.
REQ-009 SHALL have aluop  input  5  operation select.
REQ-010 SHALL have sign  input  1  compare mode for neg flag: 1 = signed, 0 = unsigned.
REQ-011 SHALL have op1, op2  input  32 each  ALU operands.
REQ-012 SHALL have result  output  32  ALU result.
REQ-013 SHALL have zero  output  1  result equals 0.
REQ-014 SHALL have neg  output  1  op1 less than op2 under the sign mode.

Function
REQ-015 PC register SHALL load pc_next on a rising clk edge when pc_write=1 and rst=0; SHALL hold its value when pc_write=0.
REQ-016 pc_plus4 SHALL be combinational from pc, width PC_W, modulo 2^PC_W (4092 -> 0 at PC_W=12).
REQ-017 The ALU SHALL be purely combinational; result, zero and neg SHALL follow input changes in the same cycle.
REQ-018 aluop encodings: 0 ADD, 1 SUB (op1-op2), 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL (logical), 7 SRA (arithmetic), 8 SLT (signed, result 1/0), 9 SLTU (unsigned, result 1/0), 10 PASSB (result=op2).
REQ-019 Unused aluop codes 11-31 SHALL produce result 0.
REQ-020 ADD/SUB SHALL wrap modulo 2^32; no overflow or carry output.
REQ-021 Shift amount SHALL be op2[4:0]; op2[31:5] ignored.
REQ-022 SLT/SLTU SHALL use their own signedness regardless of the sign input.
REQ-023 zero SHALL be 1 exactly when result is 32'h0, for every aluop.
REQ-024 neg SHALL be computed from op1 and op2 directly, independent of aluop: signed op1<op2 when sign=1, unsigned when sign=0.

Reset
REQ-025 With rst=1 on a rising edge, pc SHALL become RESET_PC, overriding pc_write and pc_next.
REQ-026 After reset release, pc_plus4 SHALL equal RESET_PC+4 with no extra latency.
REQ-027 rst SHALL NOT affect the ALU outputs.
REQ-028 Before the first reset edge pc is undefined; verification SHALL NOT check pc until reset has been applied.

Verification
REQ-029 rst=1 for one edge with pc_next=12'h0A0, pc_write=1 -> pc=0, pc_plus4=4; then rst=0, pc_write=1, pc_next=12'h010 -> pc=12'h010, pc_plus4=12'h014 after the next edge.
REQ-030 pc=12'h010, pc_write=0, pc_next=12'h200 for 3 edges -> pc stays 12'h010; pc_next=12'hFFC with pc_write=1 -> pc=12'hFFC, pc_plus4=12'h000.
REQ-031 SUB op1=5, op2=5 -> result=0, zero=1; ADD op1=32'hFFFFFFFF, op2=1 -> result=0, zero=1.
REQ-032 op1=32'hFFFFFFFF, op2=1: sign=1 -> neg=1; sign=0 -> neg=0; SLT -> result=1; SLTU -> result=0.
REQ-033 op1=32'h80000000, op2=32'h24 (shamt 4): SLL -> 0, SRL -> 32'h08000000, SRA -> 32'hF8000000.
REQ-034 AND/OR/XOR with op1=32'hF0F0F0F0, op2=32'h0FF00FF0 -> 32'h00F000F0 / 32'hFFF0FFF0 / 32'hFF00FF00; PASSB -> 32'h0FF00FF0; aluop=31 -> result=0, zero=1.
